opll_write_sequencer: RTL and testbench

OPLL_WRITE_SEQUENCER -- requirements
Module: opll_write_sequencer

---
 rtl/opll_write_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_opll_write_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/opll_write_sequencer.sv
// opll_write_sequencer
// Queues host register writes in a small FIFO and replays each one onto an
// OPLL-style chip bus as an address strobe, an address settle wait, a data
// strobe and a data settle wait. All bus outputs are registered.
//
// Optional feature: define OPLL_WRSEQ_ADDR_SKIP_EN to remember the last
// address written and skip the address phase when the next write targets
// the same register.
//
// Ports:
//   clk         - sole clock, all state on the rising edge
//   rst         - asynchronous, active-high reset
//   req_valid   - host write request valid
//   req_ready   - request accepted when high together with req_valid
//   req_addr    - OPLL register address
//   req_data    - OPLL register data
//   bus_d       - chip data bus value (i_D)
//   bus_a0      - 0 = address phase, 1 = data phase (i_A0)
//   bus_wr      - active-high write strobe (inverted externally to i_WR_n)
//   busy        - high while a transaction runs or the FIFO holds entries
//   fifo_level  - current FIFO occupancy
module opll_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STB_CYCLES = 4,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [7:0]                        req_addr,
  input  logic [7:0]                        req_data,
  output logic [7:0]                        bus_d,
  output logic                              bus_a0,
  output logic                              bus_wr,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_STB = 3'd1,
    ADDR_WT  = 3'd2,
    DATA_STB = 3'd3,
    DATA_WT  = 3'd4
  } state_t;

  state_t           state_r;
  logic [7:0]       cnt_r;
  logic [7:0]       data_stage_r;
  logic [7:0]       bus_d_r;
  logic             bus_a0_r;
  logic             bus_wr_r;
  logic             ready_r;
  logic [15:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_next_s;
  logic             push_s;
  logic             pop_s;
  logic             skip_s;
  logic [15:0]      head_s;

  // FIFO handshake decode and next occupancy
  always_comb begin
    push_s       = req_valid && ready_r;
    pop_s        = (state_r == IDLE) && (level_r != LVL_W'(0));
    head_s       = mem_r[rd_ptr_r];
    level_next_s = level_r;
    if (push_s && !pop_s) begin
      level_next_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_next_s = level_r - LVL_W'(1);
    end else begin
      level_next_s = level_r;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {req_addr, req_data};
    end
  end

  // FIFO pointers, occupancy and ready; ready is computed from the next
  // occupancy so it reflects the registered level and never allows a push
  // into a full FIFO, even on a pop edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
      ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      level_r <= level_next_s;
      ready_r <= (level_next_s != LVL_W'(FIFO_DEPTH));
    end
  end

`ifdef OPLL_WRSEQ_ADDR_SKIP_EN
  logic [7:0] last_addr_r;
  logic       last_addr_vld_r;

  assign skip_s = last_addr_vld_r && (head_s[15:8] == last_addr_r);

  // Remember the address once its strobe has completed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_r     <= 8'h00;
      last_addr_vld_r <= 1'b0;
    end else if ((state_r == ADDR_STB) && (cnt_r == 8'd0)) begin
      last_addr_r     <= bus_d_r;
      last_addr_vld_r <= 1'b1;
    end else begin
      last_addr_r     <= last_addr_r;
      last_addr_vld_r <= last_addr_vld_r;
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  // Bus sequencing FSM; one shared down-counter is loaded with (length-1)
  // on entry to each timed state and the state exits when it reaches zero.
  // bus_d/bus_a0 only change on the edge entering a strobe state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      data_stage_r <= 8'h00;
      bus_d_r      <= 8'h00;
      bus_a0_r     <= 1'b0;
      bus_wr_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            data_stage_r <= head_s[7:0];
            bus_wr_r     <= 1'b1;
            cnt_r        <= 8'(STB_CYCLES - 1);
            if (skip_s) begin
              state_r  <= DATA_STB;
              bus_a0_r <= 1'b1;
              bus_d_r  <= head_s[7:0];
            end else begin
              state_r  <= ADDR_STB;
              bus_a0_r <= 1'b0;
              bus_d_r  <= head_s[15:8];
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ADDR_STB: begin
          if (cnt_r == 8'd0) begin
            state_r  <= ADDR_WT;
            bus_wr_r <= 1'b0;
            cnt_r    <= 8'(ADDR_WAIT - 1);
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ADDR_WT: begin
          if (cnt_r == 8'd0) begin
            state_r  <= DATA_STB;
            bus_wr_r <= 1'b1;
            bus_a0_r <= 1'b1;
            bus_d_r  <= data_stage_r;
            cnt_r    <= 8'(STB_CYCLES - 1);
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        DATA_STB: begin
          if (cnt_r == 8'd0) begin
            state_r  <= DATA_WT;
            bus_wr_r <= 1'b0;
            cnt_r    <= 8'(DATA_WAIT - 1);
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        DATA_WT: begin
          if (cnt_r == 8'd0) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 8'd0;
          bus_wr_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_r;
  assign bus_d      = bus_d_r;
  assign bus_a0     = bus_a0_r;
  assign bus_wr     = bus_wr_r;
  assign fifo_level = level_r;
  assign busy       = (state_r != IDLE) || (level_r != LVL_W'(0));

endmodule

// File: tb/tb_opll_write_sequencer.sv
// tb_opll_write_sequencer
// Scoreboard bench for opll_write_sequencer with default parameters. The
// stimulus pushes the strobes each accepted write should produce (phase,
// bus value, start cycle, width) into a queue; a monitor watching bus_wr
// pops and compares every strobe it sees.
module tb_opll_write_sequencer;

  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [7:0]       req_addr = 8'h00;
  logic [7:0]       req_data = 8'h00;
  logic [7:0]       bus_d;
  logic             bus_a0;
  logic             bus_wr;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  opll_write_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .bus_d      (bus_d),
    .bus_a0     (bus_a0),
    .bus_wr     (bus_wr),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // edge counter: after rising edge n, cyc == n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       a0;
    logic [7:0] d;
    int         start;
    int         width;
  } stb_t;

  stb_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_stb(input logic a0, input logic [7:0] d, input int start, input int width);
    stb_t e;
    e.a0 = a0; e.d = d; e.start = start; e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // hold a request until accepted; returns the accepting edge index
  task automatic push(input logic [7:0] a, input logic [7:0] d, output int acc);
    logic rdy;
    acc = -1;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 400; i++) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: addr 0x%0h never accepted", a);
    end
  endtask

  // strobe monitor
  logic       prev_wr = 1'b0;
  int         s_start = 0;
  logic       s_a0 = 1'b0;
  logic [7:0] s_d = 8'h00;
  logic       s_unstable = 1'b0;

  always @(negedge clk) begin
    stb_t e;
    if (bus_wr && !prev_wr) begin
      s_start    = cyc;
      s_a0       = bus_a0;
      s_d        = bus_d;
      s_unstable = 1'b0;
    end else if (bus_wr && prev_wr) begin
      if ((bus_a0 !== s_a0) || (bus_d !== s_d)) s_unstable = 1'b1;
    end else if (!bus_wr && prev_wr) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: a0=%0d d=0x%0h start=%0d", s_a0, s_d, s_start);
      end else begin
        e = exp_q.pop_front();
        chk("stb_a0",       32'(s_a0),         32'(e.a0));
        chk("stb_d",        32'(s_d),          32'(e.d));
        chk("stb_start",    32'(s_start),      32'(e.start));
        chk("stb_width",    32'(cyc - s_start), 32'(e.width));
        chk("stb_stable",   32'(s_unstable),   32'd0);
      end
    end
    prev_wr = bus_wr;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e, f, h, h2, r, tmp;
    int acc [1:5];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_wr",     32'(bus_wr),     32'd0);
    chk("rst_bus_a0",     32'(bus_a0),     32'd0);
    chk("rst_bus_d",      32'(bus_d),      32'h00);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // single write with default timing
    push(8'h10, 8'h55, e);
    expect_stb(1'b0, 8'h10, e + 1, 4);
    expect_stb(1'b1, 8'h55, e + 17, 4);
    wait_cyc(e + 104);
    chk("busy_last_wait", 32'(busy), 32'd1);
    wait_cyc(e + 105);
    chk("busy_done", 32'(busy), 32'd0);
    chk("level_done", 32'(fifo_level), 32'd0);

    // fill the FIFO behind a running transaction, then push on the pop edge
    wait_cyc(e + 110);
    push(8'h30, 8'hA0, f);
    expect_stb(1'b0, 8'h30, f + 1, 4);
    expect_stb(1'b1, 8'hA0, f + 17, 4);
    wait_cyc(f + 2);
    for (int k = 1; k <= 4; k++) begin
      push(8'(8'h40 + k), 8'(8'hB0 + k), acc[k]);
      expect_stb(1'b0, 8'(8'h40 + k), f + 1 + 105 * k, 4);
      expect_stb(1'b1, 8'(8'hB0 + k), f + 17 + 105 * k, 4);
    end
    chk("fill_back_to_back", 32'(acc[4]), 32'(acc[1] + 3));
    chk("full_ready",        32'(req_ready), 32'd0);
    chk("full_level",        32'(fifo_level), 32'd4);
    fork
      begin
        wait_cyc(f + 106);
        chk("pop_edge_level", 32'(fifo_level), 32'd3);
      end
    join_none
    push(8'h45, 8'hB5, acc[5]);
    expect_stb(1'b0, 8'h45, f + 526, 4);
    expect_stb(1'b1, 8'hB5, f + 542, 4);
    chk("push_refused_on_pop", 32'(acc[5]), 32'(f + 107));
    chk("level_after_refill",  32'(fifo_level), 32'd4);
    wait_cyc(f + 631);
    chk("busy_after_fill", 32'(busy), 32'd0);

    // two writes to the same register; push and pop on the same edge
    wait_cyc(f + 635);
    push(8'h20, 8'h01, h);
    push(8'h20, 8'h02, h2);
    chk("second_push_next_edge", 32'(h2), 32'(h + 1));
    chk("push_pop_level", 32'(fifo_level), 32'd1);
    expect_stb(1'b0, 8'h20, h + 1, 4);
    expect_stb(1'b1, 8'h01, h + 17, 4);
`ifdef OPLL_WRSEQ_ADDR_SKIP_EN
    expect_stb(1'b1, 8'h02, h + 106, 4);
`else
    expect_stb(1'b0, 8'h20, h + 106, 4);
    expect_stb(1'b1, 8'h02, h + 122, 4);
`endif
    wait_cyc(h + 240);

    // reset in the middle of a data strobe with two entries queued
    push(8'h60, 8'h11, r);
    push(8'h61, 8'h22, tmp);
    push(8'h62, 8'h33, tmp);
    expect_stb(1'b0, 8'h60, r + 1, 4);
    expect_stb(1'b1, 8'h11, r + 17, 1);
    wait_cyc(r + 17);
    chk("queued_before_rst", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_bus_wr",    32'(bus_wr),     32'd0);
    chk("abort_level",     32'(fifo_level), 32'd0);
    chk("abort_busy",      32'(busy),       32'd0);
    chk("abort_req_ready", 32'(req_ready),  32'd0);
    chk("abort_bus_d",     32'(bus_d),      32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    repeat (300) @(negedge clk);
    chk("idle_after_abort", 32'(busy), 32'd0);
    chk("all_strobes_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
